// File: rtl/mem_dram_ctrl.sv
// DRAM access sequencer between the MEM-stage extend/merge logic and a synchronous-read data RAM.
// Loads and word stores go straight through; byte/half stores run read-modify-write via the merge logic.
module mem_dram_ctrl #(
    parameter int ADDR_W     = 14,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       merged_wd,
    output logic [31:0]       mem_rd,
    output logic              rd_valid,
    output logic              stall,
    output logic              misalign,
    output logic [ADDR_W-1:0] dram_addr,
    output logic              dram_we,
    output logic [31:0]       dram_wdata,
    input  logic [31:0]       dram_rdata
);

    // state    | meaning
    // ---------+-----------------------------------------------------------
    // IDLE     | waiting for a request; accepts loads and stores
    // RD_WAIT  | read in flight, counting RD_LATENCY cycles
    // LD_DONE  | load data in mem_rd, rd_valid high, pipeline released
    // MERGE    | old word in mem_rd, merge logic produces merged_wd
    // WRITE    | dram_we high for this single cycle, pipeline released

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_WAIT = 3'd1;
    localparam logic [2:0] ST_LD_DONE = 3'd2;
    localparam logic [2:0] ST_MERGE   = 3'd3;
    localparam logic [2:0] ST_WRITE   = 3'd4;

    localparam logic [1:0] CNT_LAST = 2'(RD_LATENCY - 1);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [1:0]        lat_cnt;
    logic              op_store;
    logic              req_misal;
    logic              req_legal;
    logic              accept;
    logic              word_store;
    logic              rd_done;
    logic [ADDR_W-1:0] req_waddr;
    logic              unused_addr;

    assign req_waddr   = req_addr[ADDR_W+1:2];
    assign unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

    always_comb begin
        req_misal = 1'b0;
        if (req_size == 2'b01 && req_addr[0]) begin
            req_misal = 1'b1;
        end
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00) begin
            req_misal = 1'b1;
        end
    end

    assign req_legal  = req_valid && (req_size != 2'b11) && !req_misal;
    assign accept     = (state == ST_IDLE) && req_legal;
    assign word_store = req_we && (req_size == 2'b10);
    assign rd_done    = (state == ST_RD_WAIT) && (lat_cnt == CNT_LAST);

    // The pipeline is held from the accept cycle up to, but not including, the done cycle.
    assign stall    = !rst_n && (accept || state == ST_RD_WAIT || state == ST_MERGE);
    assign misalign = !rst_n && (state == ST_IDLE) && req_valid && req_misal;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = word_store ? ST_WRITE : ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (rd_done) begin
                    state_nxt = op_store ? ST_MERGE : ST_LD_DONE;
                end
            end
            ST_LD_DONE: state_nxt = ST_IDLE;
            ST_MERGE:   state_nxt = ST_WRITE;
            ST_WRITE:   state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= ST_IDLE;
            lat_cnt    <= 2'd0;
            op_store   <= 1'b0;
            mem_rd     <= 32'd0;
            rd_valid   <= 1'b0;
            dram_addr  <= '0;
            dram_we    <= 1'b0;
            dram_wdata <= 32'd0;
        end else begin
            state    <= state_nxt;
            rd_valid <= (state_nxt == ST_LD_DONE);
            dram_we  <= (state_nxt == ST_WRITE);

            if (accept) begin
                dram_addr <= req_waddr;
                lat_cnt   <= 2'd0;
                op_store  <= req_we;
                if (word_store) begin
                    dram_wdata <= merged_wd;
                end
            end

            if (state == ST_RD_WAIT) begin
                lat_cnt <= lat_cnt + 2'd1;
                if (rd_done) begin
                    mem_rd <= dram_rdata;
                end
            end

            // mem_rd is stable here, so merged_wd already reflects the old word.
            if (state == ST_MERGE) begin
                dram_wdata <= merged_wd;
            end
        end
    end

endmodule

// File: tb/tb_mem_dram_ctrl.sv
// Directed bench for mem_dram_ctrl: instance 0 uses RD_LATENCY=1, instance 1 uses RD_LATENCY=3.
// A small DRAM array and byte/half merge function stand in for the RAM and the extend logic.
module tb_mem_dram_ctrl;

    logic        clk;
    logic        rst        [2];
    logic        req_valid  [2];
    logic        req_we     [2];
    logic [1:0]  req_size   [2];
    logic [31:0] req_addr   [2];
    logic [31:0] st_data    [2];
    logic [31:0] merged_wd  [2];
    logic [31:0] mem_rd     [2];
    logic        rd_valid   [2];
    logic        stall      [2];
    logic        misalign   [2];
    logic [13:0] dram_addr  [2];
    logic        dram_we    [2];
    logic [31:0] dram_wdata [2];
    logic [31:0] dram_rdata [2];

    logic [31:0] dram_mem [2][64];
    int          we_cnt   [2];
    logic        bd_we;
    int          bd_k;
    logic [5:0]  bd_addr;
    logic [31:0] bd_data;

    int n_chk;
    int n_fail;

    function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] addr,
                                               input logic [31:0] data, input logic [1:0] size);
        logic [31:0] w;
        w = old;
        case (size)
            2'b00: w[addr[1:0]*8 +: 8] = data[7:0];
            2'b01: w[addr[1]*16 +: 16] = data[15:0];
            default: w = data;
        endcase
        return w;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign merged_wd[g]  = merge_word(mem_rd[g], req_addr[g], st_data[g], req_size[g]);
        assign dram_rdata[g] = dram_mem[g][dram_addr[g][5:0]];

        mem_dram_ctrl #(
            .ADDR_W     (14),
            .RD_LATENCY ((g == 0) ? 1 : 3)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst[g]),
            .req_valid  (req_valid[g]),
            .req_we     (req_we[g]),
            .req_size   (req_size[g]),
            .req_addr   (req_addr[g]),
            .merged_wd  (merged_wd[g]),
            .mem_rd     (mem_rd[g]),
            .rd_valid   (rd_valid[g]),
            .stall      (stall[g]),
            .misalign   (misalign[g]),
            .dram_addr  (dram_addr[g]),
            .dram_we    (dram_we[g]),
            .dram_wdata (dram_wdata[g]),
            .dram_rdata (dram_rdata[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bd_we) begin
            dram_mem[bd_k][bd_addr] <= bd_data;
        end
        for (int k = 0; k < 2; k++) begin
            if (dram_we[k]) begin
                dram_mem[k][dram_addr[k][5:0]] <= dram_wdata[k];
                we_cnt[k] <= we_cnt[k] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic v, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] data);
        req_valid[k] = v;
        req_we[k]    = we;
        req_size[k]  = size;
        req_addr[k]  = addr;
        st_data[k]   = data;
    endtask

    task automatic poke(input int k, input logic [5:0] addr, input logic [31:0] data);
        bd_k    = k;
        bd_addr = addr;
        bd_data = data;
        bd_we   = 1'b1;
        cyc();
        bd_we   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int we0;
        n_chk  = 0;
        n_fail = 0;
        bd_we  = 1'b0;
        bd_k   = 0;
        bd_addr = '0;
        bd_data = '0;
        for (int k = 0; k < 2; k++) begin
            rst[k]    = 1'b1;
            we_cnt[k] = 0;
            drive(k, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        end

        // Reset forces combinational outputs low even with a legal request present
        drive(0, 1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
        #2;
        chk("rst_stall", stall[0], 0);
        chk("rst_misalign", misalign[0], 0);
        chk("rst_mem_rd", mem_rd[0], 0);
        chk("rst_rd_valid", rd_valid[0], 0);
        chk("rst_dram_we", dram_we[0], 0);
        chk("rst_dram_addr", dram_addr[0], 0);
        drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

        poke(0, 6'd4, 32'hDEADBEEF);
        poke(0, 6'd1, 32'hCAFE1234);
        poke(1, 6'd1, 32'h0BADF00D);
        poke(1, 6'd2, 32'h55667788);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        cyc();

        // Word load, latency 1
        we0 = we_cnt[0];
        cyc(); drive(0, 1'b1, 1'b0, 2'b10, 32'h10, 32'h0); #1;
        chk("lw_c0_stall", stall[0], 1);
        chk("lw_c0_misalign", misalign[0], 0);
        cyc(); #1;
        chk("lw_c1_stall", stall[0], 1);
        chk("lw_c1_addr", dram_addr[0], 4);
        chk("lw_c1_rd_valid", rd_valid[0], 0);
        cyc(); #1;
        chk("lw_c2_rd_valid", rd_valid[0], 1);
        chk("lw_c2_mem_rd", mem_rd[0], 32'hDEADBEEF);
        chk("lw_c2_stall", stall[0], 0);
        cyc(); drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0); #1;
        chk("lw_c3_rd_valid", rd_valid[0], 0);
        chk("lw_no_write", we_cnt[0] - we0, 0);

        // Byte store, read-modify-write
        poke(0, 6'd4, 32'h11223344);
        we0 = we_cnt[0];
        cyc(); drive(0, 1'b1, 1'b1, 2'b00, 32'h13, 32'h000000AA); #1;
        chk("sb_c0_stall", stall[0], 1);
        cyc(); #1;
        chk("sb_c1_stall", stall[0], 1);
        cyc(); #1;
        chk("sb_c2_mem_rd", mem_rd[0], 32'h11223344);
        chk("sb_c2_stall", stall[0], 1);
        chk("sb_c2_we", dram_we[0], 0);
        chk("sb_c2_rd_valid", rd_valid[0], 0);
        cyc(); #1;
        chk("sb_c3_we", dram_we[0], 1);
        chk("sb_c3_addr", dram_addr[0], 4);
        chk("sb_c3_wdata", dram_wdata[0], 32'hAA223344);
        chk("sb_c3_stall", stall[0], 0);
        cyc(); drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0); #1;
        chk("sb_c4_we", dram_we[0], 0);
        chk("sb_we_pulses", we_cnt[0] - we0, 1);
        chk("sb_mem", dram_mem[0][4], 32'hAA223344);

        // Word store
        we0 = we_cnt[0];
        cyc(); drive(0, 1'b1, 1'b1, 2'b10, 32'h20, 32'h12345678); #1;
        chk("sw_c0_stall", stall[0], 1);
        chk("sw_c0_we", dram_we[0], 0);
        cyc(); #1;
        chk("sw_c1_we", dram_we[0], 1);
        chk("sw_c1_addr", dram_addr[0], 8);
        chk("sw_c1_wdata", dram_wdata[0], 32'h12345678);
        chk("sw_c1_stall", stall[0], 0);
        cyc(); drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0); #1;
        chk("sw_c2_we", dram_we[0], 0);
        chk("sw_c2_stall", stall[0], 0);
        chk("sw_we_pulses", we_cnt[0] - we0, 1);

        // Misaligned and illegal-size requests are dropped without stalling
        we0 = we_cnt[0];
        cyc(); drive(0, 1'b1, 1'b0, 2'b10, 32'h02, 32'h0); #1;
        chk("mis_lw_misalign", misalign[0], 1);
        chk("mis_lw_stall", stall[0], 0);
        cyc(); drive(0, 1'b1, 1'b1, 2'b01, 32'h05, 32'h0000BEEF); #1;
        chk("mis_sh_misalign", misalign[0], 1);
        chk("mis_sh_stall", stall[0], 0);
        cyc(); drive(0, 1'b1, 1'b1, 2'b11, 32'h10, 32'h0); #1;
        chk("ill_size_stall", stall[0], 0);
        chk("ill_size_misalign", misalign[0], 0);
        cyc(); drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0); #1;
        chk("mis_idle_stall", stall[0], 0);
        chk("mis_idle_rd_valid", rd_valid[0], 0);
        chk("mis_no_write", we_cnt[0] - we0, 0);

        // Reset during MERGE of a halfword store suppresses the write
        we0 = we_cnt[0];
        cyc(); drive(0, 1'b1, 1'b1, 2'b01, 32'h06, 32'h0000BEEF); #1;
        chk("rsh_c0_stall", stall[0], 1);
        cyc(); #1;
        cyc(); #1;
        chk("rsh_c2_mem_rd", mem_rd[0], 32'hCAFE1234);
        chk("rsh_c2_stall", stall[0], 1);
        rst[0] = 1'b1;
        drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        #1;
        chk("rsh_rst_stall", stall[0], 0);
        chk("rsh_rst_mem_rd", mem_rd[0], 0);
        chk("rsh_rst_we", dram_we[0], 0);
        cyc();
        chk("rsh_rst_we2", dram_we[0], 0);
        rst[0] = 1'b0;
        cyc(); #1;
        chk("rsh_post_we", dram_we[0], 0);
        chk("rsh_post_stall", stall[0], 0);
        chk("rsh_no_write", we_cnt[0] - we0, 0);
        chk("rsh_mem_kept", dram_mem[0][1], 32'hCAFE1234);

        cyc(); drive(0, 1'b1, 1'b0, 2'b10, 32'h10, 32'h0); #1;
        chk("rlw_c0_stall", stall[0], 1);
        cyc(); #1;
        chk("rlw_c1_stall", stall[0], 1);
        cyc(); #1;
        chk("rlw_c2_rd_valid", rd_valid[0], 1);
        chk("rlw_c2_mem_rd", mem_rd[0], 32'hAA223344);
        cyc(); drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0); #1;

        // Latency 3: load then back-to-back byte store
        we0 = we_cnt[1];
        cyc(); drive(1, 1'b1, 1'b0, 2'b10, 32'h04, 32'h0); #1;
        chk("l3_c0_stall", stall[1], 1);
        for (int c = 1; c <= 3; c++) begin
            cyc(); #1;
            chk($sformatf("l3_c%0d_stall", c), stall[1], 1);
            chk($sformatf("l3_c%0d_rd_valid", c), rd_valid[1], 0);
        end
        cyc(); #1;
        chk("l3_c4_rd_valid", rd_valid[1], 1);
        chk("l3_c4_mem_rd", mem_rd[1], 32'h0BADF00D);
        chk("l3_c4_stall", stall[1], 0);
        cyc(); drive(1, 1'b1, 1'b1, 2'b00, 32'h09, 32'h00000099); #1;
        chk("l3_c5_stall", stall[1], 1);
        chk("l3_c5_rd_valid", rd_valid[1], 0);
        for (int c = 6; c <= 9; c++) begin
            cyc(); #1;
            chk($sformatf("l3_c%0d_stall", c), stall[1], 1);
            chk($sformatf("l3_c%0d_we", c), dram_we[1], 0);
        end
        chk("l3_c9_mem_rd", mem_rd[1], 32'h55667788);
        cyc(); #1;
        chk("l3_c10_we", dram_we[1], 1);
        chk("l3_c10_addr", dram_addr[1], 2);
        chk("l3_c10_wdata", dram_wdata[1], 32'h55669988);
        chk("l3_c10_stall", stall[1], 0);
        cyc(); drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0); #1;
        chk("l3_c11_we", dram_we[1], 0);
        chk("l3_we_pulses", we_cnt[1] - we0, 1);
        chk("l3_mem", dram_mem[1][2], 32'h55669988);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_dram_ctrl.md
Name: mem_dram_ctrl

Overview:
- DRAM access sequencer between the MEM-stage extend/merge logic and the synchronous-read data RAM.
- Word loads and word stores go straight through.
- Byte and halfword stores run read-modify-write: read old word, hand it to the merge logic as rd, capture the merged word, write it back.
- Drives a stall to freeze the pipeline while an access is in flight.
- Supplies the fetched word (rd) that the load-extend logic consumes.

Parameters:
- ADDR_W, 14, word-address width of the DRAM (byte address bits [ADDR_W+1:2]).
- RD_LATENCY, 1, cycles from dram_addr registered to dram_rdata valid; legal range 1..3.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-high reset (1 = reset asserted).
- req_valid  in  1  MEM stage has a memory op; held stable while stall=1.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as no-op, no stall).
- req_addr  in  32  byte address (ALU result).
- merged_wd  in  32  store data already merged/aligned by the extend logic.
- mem_rd  out  32  registered old/fetched DRAM word, fed back as rd.
- rd_valid  out  1  one-cycle pulse: mem_rd holds the load data.
- stall  out  1  combinational; 1 = hold the pipeline this cycle.
- misalign  out  1  combinational; 1 = current request is misaligned and dropped.
- dram_addr  out  ADDR_W  registered word address.
- dram_we  out  1  registered write enable.
- dram_wdata  out  32  registered write data.
- dram_rdata  in  32  DRAM read data.

Behaviour:
- Reset (async): state IDLE, latency counter 0. mem_rd, dram_addr, dram_wdata = 0; rd_valid, dram_we = 0. stall and misalign are forced to 0 while rst_n=1.
- States: IDLE, RD_WAIT, LD_DONE, MERGE, WRITE.
- Misaligned request: req_size=01 with addr[0]=1, or req_size=10 with addr[1:0]≠0.
  - misalign=1 and stall=0 in that IDLE cycle; request is dropped; no DRAM activity.
- IDLE, accepting a load or a byte/half store:
  - dram_addr <= req_addr[ADDR_W+1:2]; counter <= 0; next state RD_WAIT; stall=1.
- IDLE, accepting a word store:
  - dram_addr <= word address; dram_wdata <= merged_wd; dram_we <= 1; next state WRITE; stall=1.
- RD_WAIT: stall=1; counter increments each cycle.
  - On the edge ending the cycle where counter==RD_LATENCY-1: mem_rd <= dram_rdata.
  - Next state is LD_DONE for a load, MERGE for a byte/half store.
- LD_DONE: rd_valid=1, stall=0; next state IDLE. rd_valid is registered: set on entry, cleared on exit.
- MERGE: stall=1; mem_rd is stable, so merged_wd is valid this cycle.
  - dram_wdata <= merged_wd; dram_we <= 1; next state WRITE.
- WRITE: dram_we=1 for exactly this cycle; stall=0; next state IDLE; dram_we cleared on exit.
- Latency, counted in cycles from the accept cycle (cycle 0):
  - Load: rd_valid in cycle RD_LATENCY+1; stall high for RD_LATENCY+1 cycles.
  - Byte/half store: dram_we in cycle RD_LATENCY+2.
  - Word store: dram_we in cycle 1.
- Back-to-back requests: a new request is accepted only in IDLE. After a done cycle (LD_DONE/WRITE) there is exactly one IDLE accept cycle before the next access.
- No request, or req_size=11, in IDLE: stall=0 and all outputs hold; dram_we stays 0.
- req_valid dropping mid-sequence is illegal and is ignored; the sequence completes.
- Reset mid-operation: FSM returns to IDLE immediately. dram_we drops asynchronously, so a pending write is never issued. mem_rd is cleared.
- DRAM word address wraps naturally at ADDR_W bits; upper address bits are ignored.

Test Plan:
- Word load (RD_LATENCY=1): lw at 0x00000010 with DRAM[4]=0xDEADBEEF -> stall=1 in cycles 0–1; cycle 2 rd_valid=1, mem_rd=0xDEADBEEF, stall=0; dram_we never 1.
- Byte store: sb at 0x00000013, DRAM[4]=0x11223344, merge model returns 0xAA223344 -> mem_rd=0x11223344 in cycle 2; cycle 3 dram_we=1 with dram_addr=4 and dram_wdata=0xAA223344; dram_we=1 for exactly one cycle.
- Word store: sw 0x12345678 at 0x00000020 -> cycle 1 dram_we=1, dram_addr=8, dram_wdata=0x12345678, stall=0; stall=1 only in cycle 0.
- Misaligned: lw at 0x00000002, then sh at 0x00000005 -> misalign=1, stall=0 for each; no dram_we; state stays IDLE.
- Reset mid-op: assert rst_n during MERGE of an sh -> dram_we stays 0 throughout; mem_rd=0; stall=0. A following lw completes normally.
- RD_LATENCY=3: lw at 0x00000004 -> stall=1 in cycles 0–3; rd_valid in cycle 4. A back-to-back sb issued immediately -> accepted in cycle 5; dram_we in cycle 10.
